// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   Fractional-N baud-rate strobe generator for a UART. Each bit period is
//   div_int clocks long. A small phase accumulator stretches selected periods
//   by one clock, so the long-run average period is div_int + div_frac/2^FRAC_W.
//   The generator emits a one-cycle end-of-bit strobe and a one-cycle mid-bit
//   strobe.
//
// Ports
//   clk      : single clock, rising edge
//   rst      : synchronous, active-high reset
//   en       : run enable; low holds the generator idle and clears its phase
//   sync     : restarts the bit period on this edge (RX start-edge resync)
//   div_int  : integer clocks per bit period (0 behaves as 1)
//   div_frac : fractional clocks per bit period, in units of 1/2^FRAC_W
//   stb      : registered strobe in the cycle after the last edge of a period
//   half     : registered strobe in the cycle after the mid-period edge
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              stb,
  output logic              half
);

  // One extra bit so that a maximal div_int plus the fractional carry still fits.
  localparam int CNT_W = DIV_W + 1;

  // Zero-length periods are meaningless, so a zero divisor runs as one.
  function automatic logic [CNT_W-1:0] period_len(input logic [DIV_W-1:0] d,
                                                  input logic             c);
    logic [DIV_W-1:0] d_eff;
    d_eff = (d == '0) ? DIV_W'(1) : d;
    return {1'b0, d_eff} + CNT_W'(c);
  endfunction

  // Mid-bit point: half the period length, never earlier than edge 1.
  function automatic logic [CNT_W-1:0] mid_point(input logic [CNT_W-1:0] l);
    logic [CNT_W-1:0] h;
    h = l >> 1;
    return (h == '0) ? CNT_W'(1) : h;
  endfunction

  // cnt holds how many edges of the current period have elapsed; zero means
  // the next active edge opens a new period.
  logic [CNT_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  mid_q;

  logic              start;
  logic [FRAC_W:0]   acc_sum;
  logic [CNT_W-1:0]  len_new;
  logic [CNT_W-1:0]  len_cur;
  logic [CNT_W-1:0]  mid_cur;
  logic [CNT_W-1:0]  edge_n;

  // A resync clears the accumulator before this period's fractional step is added.
  always_comb begin
    start   = sync || (cnt == '0);
    acc_sum = {1'b0, (sync ? {FRAC_W{1'b0}} : acc)} + {1'b0, div_frac};
    len_new = period_len(div_int, acc_sum[FRAC_W]);
    len_cur = start ? len_new : len_q;
    mid_cur = start ? mid_point(len_new) : mid_q;
    edge_n  = start ? CNT_W'(1) : cnt + CNT_W'(1);
  end

  // ---- period state and registered strobes ----
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      acc  <= '0;
      stb  <= 1'b0;
      half <= 1'b0;
    end else begin
      stb  <= (edge_n == len_cur);
      half <= (edge_n == mid_cur);
      cnt  <= (edge_n == len_cur) ? '0 : edge_n;
      if (start) acc <= acc_sum[FRAC_W-1:0];
    end
  end

  // Period length and mid point are latched at period start only, so divisor
  // changes mid-period wait for the next period. Pure data: no reset needed.
  always_ff @(posedge clk) begin
    if (en && !rst && start) begin
      len_q <= len_new;
      mid_q <= mid_point(len_new);
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_gen
//   Directed bench for uart_baud_gen (DIV_W=16, FRAC_W=4). Each scenario drives
//   a sequence of clock cycles and records stb/half after every cycle as a bit
//   mask (bit k = value after cycle k). The masks are compared to hand-derived
//   edge lists.
// -----------------------------------------------------------------------------
module tb_uart_baud_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              sync = 1'b0;
  logic [DIV_W-1:0]  div_int = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              stb;
  logic              half;

  int n_tests = 0;
  int n_fail  = 0;

  uart_baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync),
    .div_int(div_int), .div_frac(div_frac),
    .stb(stb), .half(half)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n cycles. Per-cycle events: sync on cycle sync_at, rst on rst_at,
  // div_int <= div_new from cycle div_at, en low for cycles lo_from..lo_to.
  // A value of 0 disables the event.
  task automatic run(input int n, input int sync_at, input int rst_at,
                     input int div_at, input logic [DIV_W-1:0] div_new,
                     input int lo_from, input int lo_to,
                     output logic [31:0] sm, output logic [31:0] hm);
    sm = '0;
    hm = '0;
    for (int k = 1; k <= n; k++) begin
      sync = (k == sync_at);
      rst  = (k == rst_at);
      en   = !(k >= lo_from && k <= lo_to && lo_from != 0);
      if (k == div_at) div_int = div_new;
      tick();
      sm[k] = stb;
      hm[k] = half;
    end
    sync = 1'b0;
    rst  = 1'b0;
  endtask

  // Drop en for one cycle so the next scenario starts from a clean period.
  task automatic idle();
    en   = 1'b0;
    sync = 1'b0;
    rst  = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] bits(input int a, input int b = 0,
                                       input int c = 0, input int d = 0);
    logic [31:0] m;
    m = '0;
    if (a != 0) m[a] = 1'b1;
    if (b != 0) m[b] = 1'b1;
    if (c != 0) m[c] = 1'b1;
    if (d != 0) m[d] = 1'b1;
    return m;
  endfunction

  logic [31:0] sm, hm;

  initial begin
    // Reset wins even with en and sync high.
    rst = 1'b1; en = 1'b1; sync = 1'b1;
    tick();
    tick();
    check("reset_stb", {31'b0, stb}, 32'h0);
    check("reset_half", {31'b0, half}, 32'h0);
    rst = 1'b0; sync = 1'b0; en = 1'b0;
    tick();

    // Integer divisor 4: stb after 4,8,12; half after 2,6,10.
    div_int = 16'd4; div_frac = 4'd0;
    run(12, 0, 0, 0, 16'd0, 0, 0, sm, hm);
    check("div4_stb", sm, bits(4, 8, 12));
    check("div4_half", hm, bits(2, 6, 10));
    idle();

    // 4 + 8/16: lengths 4,5,4,5.
    div_int = 16'd4; div_frac = 4'd8;
    run(18, 0, 0, 0, 16'd0, 0, 0, sm, hm);
    check("frac_stb", sm, bits(4, 9, 13, 18));
    check("frac_half", hm, bits(2, 6, 11, 15));
    idle();

    // Divisor 0 then 1: both strobes on every running cycle.
    div_int = 16'd0; div_frac = 4'd0;
    run(10, 0, 0, 6, 16'd1, 0, 0, sm, hm);
    check("len1_stb", sm, 32'h0000_07FE);
    check("len1_half", hm, 32'h0000_07FE);
    idle();
    check("len1_off_stb", {31'b0, stb}, 32'h0);
    check("len1_off_half", {31'b0, half}, 32'h0);

    // Sync at edge 3 aborts the period: half 2,4,8; stb 6.
    div_int = 16'd4; div_frac = 4'd0;
    run(8, 3, 0, 0, 16'd0, 0, 0, sm, hm);
    check("sync3_stb", sm, bits(6));
    check("sync3_half", hm, bits(2, 4, 8));
    idle();

    // Same with frac 8: a cleared accumulator keeps the resynced period at 4.
    div_int = 16'd4; div_frac = 4'd8;
    run(12, 3, 0, 0, 16'd0, 0, 0, sm, hm);
    check("sync_acc_stb", sm, bits(6, 11));
    check("sync_acc_half", hm, bits(2, 4, 8));
    idle();

    // Sync on the last edge suppresses that stb.
    div_int = 16'd4; div_frac = 4'd0;
    run(8, 4, 0, 0, 16'd0, 0, 0, sm, hm);
    check("sync_len_stb", sm, bits(7));
    check("sync_len_half", hm, bits(2, 5));
    idle();

    // Divisor change mid-period applies from the next period.
    div_int = 16'd4; div_frac = 4'd0;
    run(10, 0, 0, 2, 16'd6, 0, 0, sm, hm);
    check("divchg_stb", sm, bits(4, 10));
    check("divchg_half", hm, bits(2, 7));
    idle();

    // Reset at cycle 3 discards the period; count restarts at cycle 4.
    div_int = 16'd4; div_frac = 4'd0;
    run(11, 0, 3, 0, 16'd0, 0, 0, sm, hm);
    check("rst_mid_stb", sm, bits(7, 11));
    check("rst_mid_half", hm, bits(2, 5, 9));
    idle();

    // en low for cycles 2-4 (sync pulsed while idle is ignored); restart at 5.
    div_int = 16'd4; div_frac = 4'd0;
    run(12, 3, 0, 0, 16'd0, 2, 4, sm, hm);
    check("en_gap_stb", sm, bits(8, 12));
    check("en_gap_half", hm, bits(6, 10));
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the bench must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
